uart_rx_monitor: RTL and testbench
==================================

Name: uart_rx_monitor

Overview:
- Parametrised UART receiver: oversampled, baud-timed and mid-bit sampled.
- Deserialises frames on one line into parallel bytes, with start-glitch rejection and framing-error detection.
- Sits on the UART TX pin of the mini CPU as a bench/SoC receive monitor.
- Also usable as the RX half of a future synthesizable UART peripheral.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit. Legal range is at least 4; an even value is recommended.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY_ODD, 0: parity sense (0 = even, 1 = odd). Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- uart_rx  input  1  serial line; idles high; asynchronous to clk
- rx_data  output  DATA_BITS  last good received word; held until the next good frame
- rx_valid  output  1  one-cycle pulse; rx_data updates in the same cycle
- frame_err  output  1  one-cycle pulse; a stop bit was sampled low
- parity_err  output  1  one-cycle pulse, coincident with rx_valid; constant 0 without the macro
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - rx_data = 0; rx_valid = frame_err = parity_err = busy = 0.
  - FSM = IDLE, baud counter = 0, bit counter = 0.
  - Both synchroniser flops = 1.
- Reset mid-frame aborts the frame immediately. No pulse is emitted and no partial data is kept.
- Synchroniser: 2-flop synchroniser on uart_rx, output rx_s. All decisions use rx_s only.
- Baud counter: counts 0..CLKS_PER_BIT-1, clears on every state entry. Let H = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: rx_s == 0 → START.
  - START: sample at count H-1.
    - rx_s == 1: false start (glitch) → IDLE, no pulse.
    - rx_s == 0 → DATA, counter cleared.
  - DATA:
    - Sample at count CLKS_PER_BIT-1 and shift into bit position = bit counter (LSB first).
    - After DATA_BITS samples → PARITY if the macro is defined, else STOP.
  - STOP:
    - Sample at count CLKS_PER_BIT-1, once per stop bit.
    - Any stop sample 0: pulse frame_err → BREAK. rx_data is unchanged and rx_valid is not asserted.
    - All stop samples 1, on the final stop sample edge: load rx_data, pulse rx_valid → IDLE.
  - BREAK: wait for rx_s == 1 → IDLE. This prevents a held-low line (break) re-triggering as a start.
- Latency:
  - Let T0 be the first clk edge sampling uart_rx low.
  - rx_valid asserts at T0 + 2 + H + (DATA_BITS + STOP_BITS [+1 with parity]) × CLKS_PER_BIT, ±1 cycle (the bench tolerance).
- Back-to-back frames:
  - Returning to IDLE on the final stop-bit mid-sample lets a start bit with zero idle time be detected.
  - Tolerates a sender clock error of up to ±(H-1)/(CLKS_PER_BIT × frame bits).
- No backpressure: a new good frame overwrites rx_data. The consumer must capture it on rx_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA and samples one bit at count CLKS_PER_BIT-1.
  - Expected bit = XOR of the data bits, XOR PARITY_ODD.
  - On mismatch, parity_err pulses together with rx_valid. rx_data is still delivered.
  - A frame error takes precedence: frame_err pulses and neither rx_valid nor parity_err asserts.
- Not defined:
  - No PARITY state; the frame is start + DATA_BITS + stop.
  - parity_err is tied to 0 and PARITY_ODD is ignored.

Test Plan:
- Single byte, defaults: 0x55 sent at 16 clk/bit → exactly one rx_valid pulse within the latency window, rx_data = 0x55, busy low afterwards.
- Start glitch: uart_rx low for 4 cycles then high → no rx_valid or frame_err; busy returns to 0 within H+3 cycles.
- Framing error: 0xA5 sent with stop bit 0, line held low for 40 more cycles → one frame_err pulse, rx_data keeps its prior value, no new start until the line goes high; a following 0x3C is received correctly.
- Back-to-back: 0xA5 then 0x3C with zero idle, plus DATA_BITS = 7, STOP_BITS = 2, CLKS_PER_BIT = 8 variant sending 0x5A → rx_valid pulses carry 0xA5, 0x3C and 0x5A in order.
- Reset mid-frame: rst_n low during bit 3 of 0xFF → all outputs 0 immediately; after release, 0x81 is received correctly.
- Parity (macro defined, even): 0x07 with parity bit 1 → rx_valid with parity_err = 0. Same byte with parity bit 0 → rx_valid with parity_err = 1 and rx_data = 0x07.

Source files
------------

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: oversampled mid-bit UART receiver with start-glitch rejection and framing check.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID = CW'(H - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] BRK   = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY     = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
  logic par_bit;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
  assign parity_err = 1'b0;
`endif
  logic                 rx_m, rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick_end;
  assign tick_end = cnt == CNT_END;
  assign busy     = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m      <= uart_rx;
      rx_s      <= rx_m;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START:
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (tick_end) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt == LAST_DATA ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == LAST_DATA) state <= AFTER_DATA;
          end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (tick_end) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else cnt <= cnt + 1'b1;
`endif
        STOP:
          if (tick_end) begin
            cnt <= '0;
            // a low stop sample aborts at once; the remaining stop bits are not awaited
            if (!rx_s) begin
              frame_err <= 1'b1;
              bit_cnt   <= '0;
              state     <= BRK;
            end else if (bit_cnt == LAST_STOP) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              state    <= IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bit ^ (^shreg) ^ 1'(PARITY_ODD);
`endif
            end else bit_cnt <= bit_cnt + 1'b1;
          end else cnt <= cnt + 1'b1;
        BRK:
          if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: randomized frame stimulus checked against a queue-based model of the receiver.
module tb_uart_rx_monitor;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int EXP_LAT = 2 + 8 + (8 + 1 + PEN) * 16;
  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, uart_rx2 = 1'b1;
  logic [7:0] rx_data;
  logic [6:0] rx_data2;
  logic rx_valid, frame_err, parity_err, busy;
  logic rx_valid2, frame_err2, parity_err2, busy2;
  int total = 0, bad = 0, cyc = 0, vcnt = 0, fcnt = 0, vcyc = 0, stray = 0, t0 = 0;
  int got_d[$], got_p[$], got2_d[$], got2_p[$], exp_d[$], exp_p[$];
  always #5 clk = ~clk;
  uart_rx_monitor dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );
  uart_rx_monitor #(.CLKS_PER_BIT(8), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .frame_err(frame_err2), .parity_err(parity_err2), .busy(busy2)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) begin
      if (rx_valid) begin
        got_d.push_back(int'(rx_data));
        got_p.push_back(int'(parity_err));
        vcnt++;
        vcyc = cyc;
      end
      if (rx_valid2) begin
        got2_d.push_back(int'(rx_data2));
        got2_p.push_back(int'(parity_err2));
      end
      if (frame_err || frame_err2) fcnt++;
      if ((parity_err && !rx_valid) || (parity_err2 && !rx_valid2)) stray++;
    end
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int inst, input bit b, input int n);
    if (inst == 0) uart_rx = b;
    else uart_rx2 = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input int inst, input int d, input bit stop_val, input bit flip);
    int cpb = inst ? 8 : 16;
    int nb = inst ? 7 : 8;
    int ns = inst ? 2 : 1;
    bit par = flip ^ bit'(inst);
    if (inst == 0) t0 = cyc + 1;
    drive(inst, 1'b0, cpb);
    for (int i = 0; i < nb; i++) begin
      drive(inst, d[i], cpb);
      par ^= d[i];
    end
    if (PEN) drive(inst, par, cpb);
    drive(inst, stop_val, cpb * ns);
  endtask
  task automatic exp_rx(input int inst, input string tag, input int d, input bit flip);
    int pe = PEN ? int'(flip) : 0;
    if ((inst ? got2_d.size() : got_d.size()) == 0) check(tag, -1, d);
    else if (inst == 0) begin
      check(tag, got_d.pop_front(), d);
      check({tag, "_perr"}, got_p.pop_front(), pe);
    end else begin
      check(tag, got2_d.pop_front(), d);
      check({tag, "_perr"}, got2_p.pop_front(), pe);
    end
  endtask
  initial begin
    int v0, f0, d, fl;
    repeat (2) @(negedge clk);
    check("rst_data", int'(rx_data), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_busy2", int'(busy2), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(0, 'h55, 1'b1, 1'b0);
    drive(0, 1'b1, 4);
    exp_rx(0, "single", 'h55, 1'b0);
    check("latency_window", int'(vcyc - t0 >= EXP_LAT - 1 && vcyc - t0 <= EXP_LAT + 1), 1);
    check("single_count", vcnt, 1);
    check("single_busy", int'(busy), 0);
    v0 = vcnt;
    f0 = fcnt;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 8 + 3);
    check("glitch_busy", int'(busy), 0);
    check("glitch_valid", vcnt, v0);
    check("glitch_ferr", fcnt, f0);
    send(0, 'hA5, 1'b0, 1'b0);
    drive(0, 1'b0, 40);
    check("ferr_pulse", fcnt, f0 + 1);
    check("ferr_novalid", vcnt, v0);
    check("ferr_hold_data", int'(rx_data), 'h55);
    check("ferr_break_busy", int'(busy), 1);
    drive(0, 1'b1, 32);
    check("ferr_idle", int'(busy), 0);
    send(0, 'h3C, 1'b1, 1'b0);
    drive(0, 1'b1, 4);
    exp_rx(0, "after_ferr", 'h3C, 1'b0);
    send(0, 'hA5, 1'b1, 1'b0);
    send(0, 'h3C, 1'b1, 1'b0);
    drive(0, 1'b1, 4);
    exp_rx(0, "b2b_0", 'hA5, 1'b0);
    exp_rx(0, "b2b_1", 'h3C, 1'b0);
    send(1, 'h5A, 1'b1, 1'b0);
    drive(1, 1'b1, 4);
    exp_rx(1, "narrow", 'h5A, 1'b0);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 48 + 8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", int'(rx_data), 0);
    check("mid_rst_valid", int'(rx_valid), 0);
    check("mid_rst_ferr", int'(frame_err), 0);
    check("mid_rst_perr", int'(parity_err), 0);
    check("mid_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    drive(0, 1'b1, 16);
    send(0, 'h81, 1'b1, 1'b0);
    drive(0, 1'b1, 4);
    exp_rx(0, "post_rst", 'h81, 1'b0);
    check("post_rst_count", vcnt, v0 + 1);
`ifdef UART_RX_PARITY_EN
    send(0, 'h07, 1'b1, 1'b0);
    drive(0, 1'b1, 4);
    exp_rx(0, "par_good", 'h07, 1'b0);
    send(0, 'h07, 1'b1, 1'b1);
    drive(0, 1'b1, 4);
    exp_rx(0, "par_bad", 'h07, 1'b1);
`endif
    for (int i = 0; i < 24; i++) begin
      d = int'($urandom_range(0, 255));
      fl = int'($urandom_range(0, 1));
      exp_d.push_back(d);
      exp_p.push_back(fl);
      send(0, d, 1'b1, bit'(fl));
      drive(0, 1'b1, int'($urandom_range(0, 20)));
    end
    drive(0, 1'b1, 8);
    while (exp_d.size() > 0) exp_rx(0, "rand", exp_d.pop_front(), bit'(exp_p.pop_front()));
    check("rand_extra", got_d.size(), 0);
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 127));
      fl = int'($urandom_range(0, 1));
      exp_d.push_back(d);
      exp_p.push_back(fl);
      send(1, d, 1'b1, bit'(fl));
      drive(1, 1'b1, int'($urandom_range(0, 12)));
    end
    drive(1, 1'b1, 8);
    while (exp_d.size() > 0) exp_rx(1, "rand2", exp_d.pop_front(), bit'(exp_p.pop_front()));
    check("rand2_extra", got2_d.size(), 0);
    check("total_ferr", fcnt, 1);
    check("stray_perr", stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
